// File: rtl/song_pkg.sv
// Shared constants and state encoding for the melody sequencer.
package song_pkg;

  localparam int unsigned NOTE_W_DEF     = 4;
  localparam int unsigned DUR_W_DEF      = 26;
  localparam int unsigned IDX_W_DEF      = 5;
  localparam int unsigned SONG_LEN_DEF   = 26;
  localparam int unsigned GAP_CYCLES_DEF = 2500000;

  localparam logic [1:0] SONG_ODE  = 2'd0;
  localparam logic [1:0] SONG_BDAY = 2'd1;
  localparam logic [1:0] SONG_MARY = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PLAY,
    ST_GAP,
    ST_FINISH
  } player_state_e;

endpackage

// File: rtl/song_player_if.sv
// Lookup bus between the sequencer (master) and the song note/duration table.
interface song_player_if
  import song_pkg::*;
#(
  parameter int unsigned NOTE_W = NOTE_W_DEF,
  parameter int unsigned DUR_W  = DUR_W_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF
);

  logic [1:0]        rom_song;
  logic [IDX_W-1:0]  rom_index;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_duration;

  modport master (
    output rom_song,
    output rom_index,
    input  rom_note,
    input  rom_duration
  );

  modport slave (
    input  rom_song,
    input  rom_index,
    output rom_note,
    output rom_duration
  );

endinterface

// File: rtl/song_player_dur_counter.sv
// Loadable down-counter that stops at zero and flags its final count.
module dur_counter
  import song_pkg::*;
#(
  parameter int unsigned DUR_W = DUR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [DUR_W-1:0] load_val,
  output logic             last_c
);

  logic [DUR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - DUR_W'(1);
    end
  end

  assign last_c = (count == DUR_W'(1));

endmodule

// File: rtl/song_player.sv
// Melody sequencer: walks the song table, holds each note for its duration,
// inserts an articulation gap and reports the natural end of the song.
module song_player
  import song_pkg::*;
#(
  parameter int unsigned SONG_LEN   = SONG_LEN_DEF,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int unsigned NOTE_W     = NOTE_W_DEF,
  parameter int unsigned DUR_W      = DUR_W_DEF,
  parameter int unsigned IDX_W      = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic [1:0]        song_sel,
  song_player_if.master     rom,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic              busy,
  output logic              done
);

  localparam logic HAS_GAP = (GAP_CYCLES != 0);

  player_state_e     state;
  player_state_e     next_state;

  logic              note_last_c;
  logic              gap_last_c;
  logic              note_done_c;
  logic              advance_c;
  logic              last_idx_c;
  logic              dur_zero_c;
  logic              accept_start_c;

  logic [1:0]        rom_song_d;
  logic [IDX_W-1:0]  rom_index_d;
  logic [NOTE_W-1:0] note_out_d;
  logic              note_valid_d;
  logic              busy_d;
  logic              done_d;

  assign dur_zero_c     = (rom.rom_duration == '0);
  assign last_idx_c     = (rom.rom_index == IDX_W'(SONG_LEN - 1));
  assign note_done_c    = (state == ST_PLAY) && !pause && note_last_c;
  assign advance_c      = (note_done_c && !HAS_GAP) ||
                          ((state == ST_GAP) && !pause && gap_last_c);
  assign accept_start_c = start && !stop &&
                          ((state == ST_IDLE) || (state == ST_FINISH));

  // Note length: loaded while the table answer is sampled in FETCH.
  dur_counter #(.DUR_W(DUR_W)) u_note_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == ST_FETCH),
    .en       ((state == ST_PLAY) && !pause),
    .load_val (rom.rom_duration),
    .last_c   (note_last_c)
  );

  dur_counter #(.DUR_W(DUR_W)) u_gap_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (note_done_c && HAS_GAP),
    .en       ((state == ST_GAP) && !pause),
    .load_val (DUR_W'(GAP_CYCLES)),
    .last_c   (gap_last_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rom.rom_song  <= SONG_ODE;
      rom.rom_index <= '0;
      note_out      <= '0;
      note_valid    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= next_state;
      rom.rom_song  <= rom_song_d;
      rom.rom_index <= rom_index_d;
      note_out      <= note_out_d;
      note_valid    <= note_valid_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

  // Next state; stop outranks every transition.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_FINISH: if (start) next_state = ST_FETCH;
      ST_FETCH:           next_state = dur_zero_c ? ST_FINISH : ST_PLAY;
      ST_PLAY:            if (note_done_c && HAS_GAP) next_state = ST_GAP;
      ST_GAP:             ;
      default:            next_state = ST_IDLE;
    endcase
    if (advance_c) begin
      next_state = (!last_idx_c || loop_en) ? ST_FETCH : ST_FINISH;
    end
    if (stop) begin
      next_state = ST_IDLE;
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    rom_song_d   = rom.rom_song;
    rom_index_d  = rom.rom_index;
    note_out_d   = note_out;
    done_d       = 1'b0;
    if (accept_start_c) begin
      rom_song_d  = song_sel;
      rom_index_d = '0;
    end
    if ((state == ST_FETCH) && !dur_zero_c) begin
      note_out_d = rom.rom_note;
    end
    if (advance_c) begin
      rom_index_d = last_idx_c ? '0 : rom.rom_index + IDX_W'(1);
    end
    done_d = ((state == ST_FETCH) && dur_zero_c) ||
             (advance_c && last_idx_c && !loop_en);
    if (stop) begin
      rom_index_d = '0;
      done_d      = 1'b0;
    end
    busy_d       = (next_state == ST_FETCH) || (next_state == ST_PLAY) ||
                   (next_state == ST_GAP);
    note_valid_d = (next_state == ST_PLAY) && !pause;
  end

endmodule

// File: tb/tb_song_player.sv
// Directed bench for song_player with a 4-entry table per song and a 2-cycle gap.
module tb_song_player;
  import song_pkg::*;

  localparam int unsigned SONG_LEN   = 4;
  localparam int unsigned GAP_CYCLES = 2;
  localparam int unsigned NOTE_W     = 4;
  localparam int unsigned DUR_W      = 26;
  localparam int unsigned IDX_W      = 5;

  // Song tables: 0 = reference melody, 1 = long first note, 2 = latch target, 3 = end marker at index 2.
  localparam int NOTE_T [4][4] = '{'{2, 3, 4, 5}, '{9, 10, 11, 12}, '{13, 14, 15, 1}, '{6, 7, 8, 9}};
  localparam int DUR_T  [4][4] = '{'{3, 1, 2, 4}, '{5, 1, 1, 1},    '{2, 2, 2, 2},     '{3, 1, 0, 2}};

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic              pause;
  logic              loop_en;
  logic [1:0]        song_sel;
  logic [NOTE_W-1:0] note_out;
  logic              note_valid;
  logic              busy;
  logic              done;

  song_player_if #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .IDX_W(IDX_W)) rom_if ();

  song_player #(
    .SONG_LEN   (SONG_LEN),
    .GAP_CYCLES (GAP_CYCLES),
    .NOTE_W     (NOTE_W),
    .DUR_W      (DUR_W),
    .IDX_W      (IDX_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .loop_en    (loop_en),
    .song_sel   (song_sel),
    .rom        (rom_if.master),
    .note_out   (note_out),
    .note_valid (note_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always_comb begin
    rom_if.rom_note     = '0;
    rom_if.rom_duration = '0;
    if (rom_if.rom_index < 5'd4) begin
      rom_if.rom_note     = NOTE_W'(NOTE_T[rom_if.rom_song][rom_if.rom_index[1:0]]);
      rom_if.rom_duration = DUR_W'(DUR_T[rom_if.rom_song][rom_if.rom_index[1:0]]);
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Per-cycle trace, index = cycles since the start request was presented.
  logic [127:0] vmask;
  logic [127:0] dmask;
  logic [127:0] bmask;
  logic [3:0]   note_log [128];
  logic [4:0]   idx_log  [128];
  logic [1:0]   song_log [128];
  int           rel;

  task automatic sample();
    if (rel < 128) begin
      vmask[rel]    = note_valid;
      dmask[rel]    = done;
      bmask[rel]    = busy;
      note_log[rel] = note_out;
      idx_log[rel]  = rom_if.rom_index;
      song_log[rel] = rom_if.rom_song;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rel++;
    sample();
  endtask

  task automatic begin_cap();
    rel   = 0;
    vmask = '0;
    dmask = '0;
    bmask = '0;
    sample();
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_note"},  128'(note_out),         128'd0);
    check_eq({tag, "_valid"}, 128'(note_valid),       128'd0);
    check_eq({tag, "_busy"},  128'(busy),             128'd0);
    check_eq({tag, "_done"},  128'(done),             128'd0);
    check_eq({tag, "_idx"},   128'(rom_if.rom_index), 128'd0);
    check_eq({tag, "_song"},  128'(rom_if.rom_song),  128'd0);
  endtask

  logic [127:0] m_ref;
  logic [127:0] exp_loop;
  int           bad;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    pause    = 1'b0;
    loop_en  = 1'b0;
    song_sel = SONG_ODE;
    rel      = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;

    // Reference song: note runs at 2-4, 8, 12-13, 17-20; done in cycle 23.
    song_sel = SONG_ODE;
    start    = 1'b1;
    begin_cap();
    step();
    start = 1'b0;
    repeat (26) step();
    check_eq("t1_valid_mask", 128'(vmask[31:0]), 128'h001E311C);
    check_eq("t1_done_mask",  128'(dmask[31:0]), 128'h00800000);
    check_eq("t1_busy_mask",  128'(bmask[27:0]), 128'h07FFFFE);
    check_eq("t1_note0",      128'(note_log[2]),  128'd2);
    check_eq("t1_gap_hold",   128'(note_log[5]),  128'd2);
    check_eq("t1_note1",      128'(note_log[8]),  128'd3);
    check_eq("t1_note2",      128'(note_log[12]), 128'd4);
    check_eq("t1_note3",      128'(note_log[17]), 128'd5);

    // Looping from FINISH: 22-cycle period, no done pulse.
    loop_en = 1'b1;
    start   = 1'b1;
    begin_cap();
    step();
    start = 1'b0;
    repeat (69) step();
    m_ref    = 128'h1E311C;
    exp_loop = m_ref | (m_ref << 22) | (m_ref << 44) | (m_ref << 66);
    check_eq("t2_valid_mask", 128'(vmask[69:0]), 128'(exp_loop[69:0]));
    check_eq("t2_no_done",    128'(dmask[69:0]), 128'd0);
    check_eq("t2_loop2_note0", 128'(note_log[46]), 128'd2);
    check_eq("t2_loop2_note3", 128'(note_log[61]), 128'd5);
    check_eq("t2_loop3_note0", 128'(note_log[68]), 128'd2);
    stop    = 1'b1;
    loop_en = 1'b0;
    step();
    stop = 1'b0;
    check_eq("t2_stop_busy", 128'(busy), 128'd0);

    // Pause 10 cycles from the 2nd PLAY cycle of a 5-cycle note.
    song_sel = SONG_BDAY;
    start    = 1'b1;
    begin_cap();
    step();
    start = 1'b0;
    step();
    step();
    pause = 1'b1;
    repeat (10) step();
    pause = 1'b0;
    repeat (7) step();
    check_eq("t3_valid_mask", 128'(vmask[19:0]), 128'h1C00C);
    bad = 0;
    for (int c = 2; c <= 16; c++) if (note_log[c] != 4'd9) bad++;
    check_eq("t3_note_hold",  128'(bad), 128'd0);
    check_eq("t3_idx1_valid", 128'(vmask[20]),    128'd1);
    check_eq("t3_idx1_note",  128'(note_log[20]), 128'd10);
    check_eq("t3_idx1_index", 128'(idx_log[20]),  128'd1);

    // Stop together with start while playing index 1.
    stop  = 1'b1;
    start = 1'b1;
    step();
    stop  = 1'b0;
    start = 1'b0;
    check_eq("t5_busy",  128'(busy),             128'd0);
    check_eq("t5_valid", 128'(note_valid),       128'd0);
    check_eq("t5_index", 128'(rom_if.rom_index), 128'd0);
    check_eq("t5_done",  128'(done),             128'd0);
    step();
    check_eq("t5_idle_stays", 128'(busy), 128'd0);
    start = 1'b1;
    begin_cap();
    step();
    start = 1'b0;
    step();
    check_eq("t5_replay_idx",   128'(idx_log[1]),  128'd0);
    check_eq("t5_replay_valid", 128'(vmask[2]),    128'd1);
    check_eq("t5_replay_note",  128'(note_log[2]), 128'd9);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Zero duration at index 2 ends the song after index 1's gap.
    song_sel = 2'd3;
    start    = 1'b1;
    begin_cap();
    step();
    start = 1'b0;
    repeat (14) step();
    check_eq("t4_valid_mask", 128'(vmask[15:0]), 128'h011C);
    check_eq("t4_done_mask",  128'(dmask[15:0]), 128'h1000);
    check_eq("t4_busy_mask",  128'(bmask[15:0]), 128'h0FFE);
    check_eq("t4_last_note",  128'(note_log[12]), 128'd7);

    // Reset mid-gap, then song_sel changes while busy must not take effect.
    song_sel = SONG_ODE;
    start    = 1'b1;
    begin_cap();
    step();
    start = 1'b0;
    step();
    step();
    song_sel = SONG_MARY;
    repeat (5) step();
    check_eq("t6_sel_ignored_note", 128'(note_log[8]), 128'd3);
    check_eq("t6_sel_ignored_song", 128'(song_log[8]), 128'd0);
    step();
    rst_n = 1'b0;
    step();
    check_reset("t6_midgap_reset");
    rst_n = 1'b1;

    song_sel = SONG_ODE;
    start    = 1'b1;
    begin_cap();
    step();
    start = 1'b0;
    step();
    step();
    song_sel = SONG_MARY;
    repeat (21) step();
    check_eq("t6_done_mask", 128'(dmask[24:0]),  128'h0800000);
    check_eq("t6_song_held", 128'(song_log[20]), 128'd0);
    check_eq("t6_old_note3", 128'(note_log[17]), 128'd5);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("t6_new_valid", 128'(vmask[26]),    128'd1);
    check_eq("t6_new_note",  128'(note_log[26]), 128'd13);
    check_eq("t6_new_song",  128'(song_log[26]), 128'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
